// File: rtl/feature_stream_ctrl.sv
// Feature stream controller: clears a FWFT feature buffer, fills it with one
// IMG_W x IMG_H frame from upstream, then streams it downstream with
// column/row position and line/frame flags.
// Optional stall counter selected by macro FEATURE_STREAM_STALL_CNT_EN.
module feature_stream_ctrl #(
    parameter int IMG_W = 27,
    parameter int IMG_H = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     fifo_rst,
    output logic                     fifo_wr_en,
    output logic                     fifo_rd_en,
    input  logic                     fifo_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic                     out_sol,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              stall_cnt
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int WW   = $clog2(NPIX + 1);

    localparam logic [WW-1:0] LAST_WR = WW'(NPIX - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, STREAM, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wr_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          at_eol;
    logic          at_eof;

    assign at_eol  = (col == COL_MAX);
    assign at_eof  = at_eol && (row == ROW_MAX);
    assign out_col = col;
    assign out_row = row;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe/flag decode
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        fifo_rst   = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        out_sol    = 1'b0;
        out_eol    = 1'b0;
        out_eof    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                fifo_rst  = 1'b1;
                state_nxt = FILL;
            end
            FILL: begin
                in_ready   = 1'b1;
                fifo_wr_en = in_valid;
                if (in_valid && wr_cnt == LAST_WR) state_nxt = STREAM;
            end
            STREAM: begin
                out_valid  = fifo_valid;
                fifo_rd_en = fifo_valid && out_ready;
                out_sol    = fifo_valid && (col == '0);
                out_eol    = fifo_valid && at_eol;
                out_eof    = fifo_valid && at_eof;
                if (fifo_rd_en && at_eof) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accepted-write counter for the fill phase
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) wr_cnt <= '0;
        else if (fifo_wr_en)       wr_cnt <= wr_cnt + 1'b1;
    end

    // Position of the presented feature; the eof read wraps back to 0/0
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            col <= '0;
            row <= '0;
        end else if (fifo_rd_en) begin
            if (at_eol) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef FEATURE_STREAM_STALL_CNT_EN
    // Saturating count of cycles a presented feature waits on downstream
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/feature_stream_ctrl.md
FEATURE_STREAM_CTRL -- requirements
Module: feature_stream_ctrl

Interface
REQ-001 SHALL provide parameter IMG_W, default 27, image width in pixels.
REQ-002 SHALL provide parameter IMG_H, default 27, image height in pixels.
REQ-003 SHALL provide: clk  input  1  rising-edge clock.
REQ-004 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide: start  input  1  begin one frame (load, then stream).
REQ-006 SHALL provide: in_valid  input  1  upstream pixel present.
REQ-007 SHALL provide: in_ready  output  1  controller accepts upstream pixel.
REQ-008 SHALL provide: fifo_rst  output  1  one-cycle clear to the feature buffer.
REQ-009 SHALL provide: fifo_wr_en  output  1  write strobe to the feature buffer.
REQ-010 SHALL provide: fifo_rd_en  output  1  read-advance strobe to the FWFT feature buffer.
REQ-011 SHALL provide: fifo_valid  input  1  feature buffer head word valid.
REQ-012 SHALL provide: out_valid  output  1  feature at buffer head is presented downstream.
REQ-013 SHALL provide: out_ready  input  1  downstream consumes the presented feature.
REQ-014 SHALL provide: out_col, out_row  output  $clog2(IMG_W), $clog2(IMG_H)  position of the presented feature.
REQ-015 SHALL provide: out_sol, out_eol, out_eof  output  1 each  start-of-line, end-of-line, last-pixel flags.
REQ-016 SHALL provide: busy  output  1  state != IDLE; done  output  1  frame-complete pulse.
REQ-017 SHALL provide: stall_cnt  output  16  downstream backpressure cycle count.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, FILL, STREAM, DONE.
REQ-019 IDLE: start=1 -> CLEAR; start in any other state SHALL be ignored.
REQ-020 CLEAR: fifo_rst=1 for exactly one cycle; next state FILL.
REQ-021 FILL: in_ready=1; fifo_wr_en = in_valid; write counter (width $clog2(IMG_W*IMG_H+1)) increments per write.
REQ-022 FILL -> STREAM on the cycle the IMG_W*IMG_H-th write occurs (729 by default); in_ready=0 from the following cycle.
REQ-023 STREAM: out_valid = fifo_valid; fifo_rd_en = out_valid & out_ready (combinational, zero latency).
REQ-024 fifo_valid=0 in STREAM SHALL deassert out_valid; col/row hold; no read issued.
REQ-025 out_col/out_row SHALL start at 0/0 and advance only on fifo_rd_en; col wraps IMG_W-1 -> 0 with row+1.
REQ-026 out_sol = (col==0), out_eol = (col==IMG_W-1), out_eof = out_eol & (row==IMG_H-1); all qualified by out_valid.
REQ-027 Read at eof -> DONE; DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-028 start asserted during DONE SHALL be ignored; a new frame requires start in IDLE.
REQ-029 Outside FILL: in_ready=0, fifo_wr_en=0; outside STREAM: out_valid=0, fifo_rd_en=0.
REQ-030 busy SHALL be 1 in CLEAR, FILL, STREAM, DONE.

Reset
REQ-031 rst SHALL force IDLE and zero all counters on the next edge, including mid-FILL or mid-STREAM.
REQ-032 Reset values: in_ready, fifo_rst, fifo_wr_en, fifo_rd_en, out_valid, flags, busy, done = 0; out_col/out_row = 0; stall_cnt = 0.
REQ-033 rst SHALL take precedence over start in the same cycle.

Configuration
REQ-034 Macro FEATURE_STREAM_STALL_CNT_EN SHALL select the stall counter.
REQ-035 Defined: stall_cnt increments each STREAM cycle with out_valid=1, out_ready=0, saturates at 16'hFFFF, clears on CLEAR.
REQ-036 Undefined: stall_cnt SHALL be constant 0 with no counter logic.

Verification
REQ-037 rst, start pulse, in_valid held 1 -> fifo_rst one cycle, then exactly 729 fifo_wr_en cycles, then in_ready=0.
REQ-038 STREAM with out_ready=1, fifo_valid=1 -> 729 reads; out_eol at col 26 on each row; out_eof at (26,26); done pulses once; busy=0 after.
REQ-039 out_ready toggled 1/0 every cycle -> col/row advance only on ready cycles; stall_cnt=728 or 729 (macro on), 0 (macro off).
REQ-040 rst asserted at read 100 (row 3, col 19) -> next cycle IDLE, out_col/out_row=0, out_valid=0; subsequent start replays full frame.
REQ-041 start pulsed during FILL and during DONE -> no effect on state, counters or fifo_rst.
REQ-042 in_valid gapped (1 of 3 cycles) during FILL -> fifo_wr_en only when in_valid; STREAM entered after 729th accepted write.
